// File: rtl/pipe_stage_elastic_if.sv
// Upstream and downstream handshake bundle of one elastic pipeline stage.
// A transfer happens on a rising clock edge exactly when valid and ready are both high on that side.
// Valid never depends on ready. Data and control must be meaningful whenever valid is high.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 102,
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  // slave: the stage itself; master: the surrounding pipeline (or a bench)
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Back-pressurable pipeline stage register with an optional skid entry, flush and bubble masking.
// The FSM state encoding equals the entry count, so occupancy doubles as the state debug view.
module pipe_stage_elastic #(
  parameter int DATA_W = 102,
  parameter int CTRL_W = 5,
  parameter int SKID   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_elastic_if.slave   bus,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic              ready_q;
  logic              out_valid;
  logic              acc, deq;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid     = (state_q != EMPTY);
  assign acc           = bus.in_valid & bus.in_ready;
  assign deq           = out_valid & bus.out_ready;

  // With a skid entry in_ready is purely registered; without it the stage relies on out_ready.
  assign bus.in_ready  = ~rst & ((SKID != 0) ? ready_q : (~out_valid | bus.out_ready));
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  assign occupancy     = state_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = MAIN;
            load_main_in = 1'b1;
          end
        end
        MAIN: begin
          if (acc && deq) begin
            load_main_in = 1'b1;
          end else if (acc && (SKID != 0)) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            state_d        = MAIN;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      ready_q     <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      if (load_main_in) begin
        main_data_q <= bus.in_data;
        main_ctrl_q <= bus.in_ctrl;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
        skid_data_q <= '0;
        skid_ctrl_q <= '0;
      end
      if (load_skid) begin
        skid_data_q <= bus.in_data;
        skid_ctrl_q <= bus.in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a SKID=1 and a SKID=0 instance share stimulus; each has its own FIFO model.
module tb_pipe_stage_elastic;
  localparam int DATA_W = 102;
  localparam int CTRL_W = 5;
  localparam int W      = DATA_W + CTRL_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [1:0] occ_dut1, occ_dut0;

  pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus1 ();
  pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus0 ();

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .occupancy(occ_dut1)
  );
  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) u_single (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .occupancy(occ_dut0)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp0_q[$];
  int occ1 = 0;
  int occ0 = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitors: pop on every observed output transfer
  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (exp1_q.size() == 0) begin
        total++; bad++;
        $display("FAIL skid1_unexpected_out actual=%0h required=none", {bus1.out_ctrl, bus1.out_data});
      end else begin
        chk("skid1_out", 128'({bus1.out_ctrl, bus1.out_data}), 128'(exp1_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      if (exp0_q.size() == 0) begin
        total++; bad++;
        $display("FAIL skid0_unexpected_out actual=%0h required=none", {bus0.out_ctrl, bus0.out_data});
      end else begin
        chk("skid0_out", 128'({bus0.out_ctrl, bus0.out_data}), 128'(exp0_q.pop_front()));
      end
    end
  end

  // driver: one clock cycle of stimulus plus handshake checks against the entry-count model
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    logic rdy1, rdy0, acc1, acc0, deq1, deq0;
    bus1.in_valid = iv; bus1.in_data = d; bus1.in_ctrl = c; bus1.out_ready = ordy;
    bus0.in_valid = iv; bus0.in_data = d; bus0.in_ctrl = c; bus0.out_ready = ordy;
    flush = fl;
    rdy1 = (occ1 < 2);
    rdy0 = (occ0 == 0) || ordy;
    @(negedge clk);
    chk("skid1_in_ready",  128'(bus1.in_ready),  128'(rdy1));
    chk("skid1_out_valid", 128'(bus1.out_valid), 128'(occ1 > 0));
    chk("skid1_occupancy", 128'(occ_dut1),       128'(occ1));
    chk("skid0_in_ready",  128'(bus0.in_ready),  128'(rdy0));
    chk("skid0_out_valid", 128'(bus0.out_valid), 128'(occ0 > 0));
    chk("skid0_occupancy", 128'(occ_dut0),       128'(occ0));
    if (occ1 == 0) chk("skid1_bubble_ctrl", 128'(bus1.out_ctrl), 128'(0));
    if (occ0 == 0) chk("skid0_bubble_ctrl", 128'(bus0.out_ctrl), 128'(0));
    acc1 = iv && rdy1; deq1 = (occ1 > 0) && ordy;
    acc0 = iv && rdy0; deq0 = (occ0 > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      exp1_q.delete(); exp0_q.delete(); occ1 = 0; occ0 = 0;
    end else begin
      if (acc1) exp1_q.push_back({c, d});
      if (acc0) exp0_q.push_back({c, d});
      occ1 = occ1 + int'(acc1) - int'(deq1);
      occ0 = occ0 + int'(acc0) - int'(deq0);
    end
    #1;
  endtask

  task automatic do_reset(input logic ordy);
    rst = 1'b1; flush = 1'b0;
    bus1.in_valid = 1'b0; bus0.in_valid = 1'b0;
    bus1.out_ready = ordy; bus0.out_ready = ordy;
    #1;
    chk("rst_in_ready1", 128'(bus1.in_ready), 128'(0));
    chk("rst_in_ready0", 128'(bus0.in_ready), 128'(0));
    @(posedge clk);
    #1;
    exp1_q.delete(); exp0_q.delete(); occ1 = 0; occ0 = 0;
    chk("rst_out_valid1", 128'(bus1.out_valid), 128'(0));
    chk("rst_out_data1",  128'(bus1.out_data),  128'(0));
    chk("rst_out_ctrl1",  128'(bus1.out_ctrl),  128'(0));
    chk("rst_occ1",       128'(occ_dut1),       128'(0));
    chk("rst_out_data0",  128'(bus0.out_data),  128'(0));
    chk("rst_occ0",       128'(occ_dut0),       128'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready1", 128'(bus1.in_ready), 128'(1));
    chk("post_rst_in_ready0", 128'(bus0.in_ready), 128'(1));
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  initial begin
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_ctrl = '0; bus1.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_ctrl = '0; bus0.out_ready = 1'b0;
    do_reset(1'b0);

    // streaming 1..4 at full rate
    for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 5'b10001, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // back-pressure into the skid entry, then release
    cycle(1'b1, DATA_W'(8'h11), 5'b00011, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(8'h22), 5'b00101, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // flush with a full stage and a live incoming entry
    cycle(1'b1, DATA_W'(8'h33), 5'b00001, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(8'h44), 5'b00001, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(8'h99), 5'b11111, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // bubbles between two instructions
    cycle(1'b1, DATA_W'(5), 5'b00001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, DATA_W'(6), 5'b00001, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // SKID=0 replace-on-output: fill, stall, then release with a new input
    cycle(1'b1, DATA_W'(8'h55), 5'b01001, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(8'h66), 5'b01001, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(8'h77), 5'b01001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // reset mid-operation with one held entry and a stalled consumer
    cycle(1'b1, DATA_W'(8'h7a), 5'b10001, 1'b0, 1'b0);
    do_reset(1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_data(), CTRL_W'($urandom_range(0, 31)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    // drain and confirm nothing was lost
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("skid1_drained", 128'(exp1_q.size()), 128'(0));
    chk("skid0_drained", 128'(exp0_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
